// File: rtl/mbus_master.sv
// Main-bus master: takes one burst command at a time and runs it on the
// multiplexed AddrData bus as one address cycle followed by BURST data beats.
//
// state  | meaning
// S_IDLE | waiting for a command, cmd_ready high
// S_ADDR | address cycle, AddrValid strobe on the bus
// S_DATA | BURST data beats, write driven or read sampled
// S_DONE | completion pulse, forces one idle bus cycle
module mbus_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BURST  = 4
) (
  input  logic                    clk,
  input  logic                    resetH,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [BURST*DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0]       ad_out,
  output logic                    ad_oe,
  input  logic [DATA_W-1:0]       ad_in,
  output logic                    addr_valid,
  output logic                    rw,
  output logic [BURST*DATA_W-1:0] rdata,
  output logic                    done,
  output logic                    busy
);
  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      lat_rw_q, lat_rw_d;
  logic [ADDR_W-1:0]         lat_addr_q, lat_addr_d;
  logic [BURST*DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [BURST*DATA_W-1:0]   rdata_q, rdata_d;
  logic                      ready_q, ready_d;
  logic [DATA_W-1:0]         ad_out_q, ad_out_d;
  logic                      ad_oe_q, ad_oe_d;
  logic                      av_q, av_d;
  logic                      rw_out_q, rw_out_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      lat_rw_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      av_q        <= 1'b0;
      rw_out_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lat_rw_q    <= lat_rw_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      av_q        <= av_d;
      rw_out_q    <= rw_out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_rw_d    = lat_rw_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          lat_rw_d    = cmd_rw;
          lat_addr_d  = cmd_addr;
          lat_wdata_d = cmd_wdata;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        beat_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (lat_rw_q) rdata_d[int'(beat_q)*DATA_W +: DATA_W] = ad_in;
        if (beat_q == LAST_BEAT) state_d = S_DONE;
        else                     beat_d  = beat_q + 1'b1;
      end
      default: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the pins come straight off flops.
    ready_d  = 1'b0;
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    av_d     = 1'b0;
    rw_out_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_ADDR: begin
        av_d     = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = DATA_W'(lat_addr_d);
        rw_out_d = lat_rw_d;
        busy_d   = 1'b1;
      end
      S_DATA: begin
        rw_out_d = lat_rw_d;
        busy_d   = 1'b1;
        if (!lat_rw_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = lat_wdata_d[int'(beat_d)*DATA_W +: DATA_W];
        end
      end
      default: done_d = 1'b1;
    endcase
  end

  assign cmd_ready  = ready_q;
  assign ad_out     = ad_out_q;
  assign ad_oe      = ad_oe_q;
  assign addr_valid = av_q;
  assign rw         = rw_out_q;
  assign rdata      = rdata_q;
  assign done       = done_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mbus_master.sv
// Bench for mbus_master: each accepted command expands into its expected
// bus trace (address, BURST beats, done), compared cycle by cycle.
module tb_mbus_master;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            resetH;
  logic            cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0]   cmd_addr;
  logic [NB*DW-1:0] cmd_wdata;
  logic [DW-1:0]   ad_out, ad_in;
  logic            ad_oe, addr_valid, rw, done, busy;
  logic [NB*DW-1:0] rdata;

  mbus_master #(.ADDR_W(AW), .DATA_W(DW), .BURST(NB)) dut (
    .clk(clk), .resetH(resetH), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .addr_valid(addr_valid),
    .rw(rw), .rdata(rdata), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ready, av, oe, rw, busy, done, chk_rdata, rd_beat;
    logic [DW-1:0] out;
    int            beat;
  } exp_t;

  exp_t             expq[$];
  logic [DW-1:0]    rd_pat[$];
  logic [NB*DW-1:0] model_rdata = '0;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.ready = 1'b0; e.av = 1'b0; e.oe = 1'b0; e.rw = 1'b0; e.busy = 1'b0;
    e.done = 1'b0; e.chk_rdata = 1'b0; e.rd_beat = 1'b0; e.out = '0; e.beat = 0;
    return e;
  endfunction

  task automatic push_txn(input logic r, input logic [AW-1:0] a, input logic [NB*DW-1:0] wd);
    exp_t e;
    e = blank(); e.av = 1'b1; e.oe = 1'b1; e.out = a; e.rw = r; e.busy = 1'b1;
    expq.push_back(e);
    for (int k = 0; k < NB; k++) begin
      e = blank(); e.rw = r; e.busy = 1'b1; e.beat = k; e.rd_beat = r;
      e.oe = !r; e.out = r ? '0 : wd[k*DW +: DW];
      expq.push_back(e);
    end
    e = blank(); e.done = 1'b1; e.chk_rdata = 1'b1;
    expq.push_back(e);
  endtask

  // One bus cycle: check the current cycle, then present inputs for the next edge.
  task automatic tick(input logic v, input logic r, input logic [AW-1:0] a,
                      input logic [NB*DW-1:0] wd);
    exp_t e;
    @(negedge clk);
    if (expq.size() > 0) e = expq.pop_front();
    else begin
      e = blank(); e.ready = 1'b1; e.chk_rdata = 1'b1;
    end
    check("cmd_ready", 64'(cmd_ready), 64'(e.ready));
    check("addr_valid", 64'(addr_valid), 64'(e.av));
    check("ad_oe", 64'(ad_oe), 64'(e.oe));
    check("ad_out", 64'(ad_out), 64'(e.out));
    check("rw", 64'(rw), 64'(e.rw));
    check("busy", 64'(busy), 64'(e.busy));
    check("done", 64'(done), 64'(e.done));
    if (e.chk_rdata) check("rdata", rdata, model_rdata);
    if (e.rd_beat) begin
      ad_in = (rd_pat.size() > 0) ? rd_pat.pop_front() : DW'($urandom);
      model_rdata[e.beat*DW +: DW] = ad_in;
    end else begin
      ad_in = DW'($urandom);
    end
    cmd_valid = v; cmd_rw = r; cmd_addr = a; cmd_wdata = wd;
    if (v && e.ready) push_txn(r, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    resetH = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; ad_in = '0;
    repeat (3) @(negedge clk);
    resetH = 1'b0;
    idle(10);

    // directed write then read
    tick(1'b1, 1'b0, 16'h2010, {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0});
    idle(8);
    rd_pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tick(1'b1, 1'b1, 16'h2010, '0);
    idle(6);
    check("rdata_directed", rdata, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    idle(2);

    // back-to-back: cmd_valid held high across two commands
    tick(1'b1, 1'b0, 16'h5A00, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 16'h7B11, '0);
    idle(10);

    // cmd_valid pulse in the DATA phase of a write must be ignored
    tick(1'b1, 1'b0, 16'h3300, 64'hFEDC_BA98_7654_3210);
    idle(2);
    tick(1'b1, 1'b1, 16'h9999, '0);
    idle(8);

    // reset asserted during the second read beat
    tick(1'b1, 1'b1, 16'h4242, '0);
    idle(3);
    #2 resetH = 1'b1;
    #1;
    check("rst_ad_oe", 64'(ad_oe), 64'd0);
    check("rst_addr_valid", 64'(addr_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rdata", rdata, 64'd0);
    expq.delete();
    model_rdata = '0;
    idle(3);
    resetH = 1'b0;
    idle(2);
    tick(1'b1, 1'b1, 16'h1234, '0);
    idle(8);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) == 0, 1'($urandom), AW'($urandom),
           {$urandom, $urandom});
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
